date_counter: RTL

Day-of-month and month counter for the millennium clock. It sits directly upstream of the year counter: it advances on the day rollover from the time-of-day chain and produces the New-Year carry that the year counter consumes. It reads the current year back for leap-year handling. It also supports manual day/month adjustment through the shared up/down/select controls.

---
 rtl/date_counter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/date_counter.sv
// rtl/date_counter.sv - day-of-month and month counter with leap-year handling and New-Year carry
//
// Purpose: advances day/month on the day-rollover carry from the time-of-day
// chain, supports manual day/month adjustment via up/down/select_item, clamps
// the day when the year or month shrinks the current month, and produces the
// New-Year carry consumed by the year counter.
//
// Ports:
//   clk_1Hz      in   system clock, all state changes on rising edge
//   rst          in   asynchronous active-high reset
//   en_1         in   global count enable
//   carry_in     in   day-rollover carry from the hour counter
//   up, down     in   debounced adjust button levels
//   select_item  in   field under adjustment (3'b011 day, 3'b100 month)
//   year_bin     in   current year 2001..3000
//   day_bin      out  day of month 1..31
//   month_bin    out  month 1..12
//   carry_out    out  New-Year carry (combinational)
module date_counter (
  input  logic        clk_1Hz,
  input  logic        rst,
  input  logic        en_1,
  input  logic        carry_in,
  input  logic        up,
  input  logic        down,
  input  logic [2:0]  select_item,
  input  logic [11:0] year_bin,
  output logic [4:0]  day_bin,
  output logic [3:0]  month_bin,
  output logic        carry_out
);

  localparam logic [2:0] SELECT_DAY   = 3'b011;
  localparam logic [2:0] SELECT_MONTH = 3'b100;

  logic [4:0] day_q, day_d;
  logic [3:0] month_q, month_d;
  logic       up_q, up_d;
  logic       down_q, down_d;

  logic       century_skip;
  logic       leap;
  logic       up_p, down_p;
  logic       adj_day, adj_month, adj_mode;
  logic       count_ev;
  logic       step_ev;
  logic [3:0] month_adj;
  logic [4:0] dim_cur, dim_new;

  function automatic logic [4:0] days_in(input logic [3:0] m, input logic lp);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: days_in = 5'd30;
      4'd2:                    days_in = lp ? 5'd29 : 5'd28;
      default:                 days_in = 5'd31;
    endcase
  endfunction

  // Century years in range that are not divisible by 400 (2400 and 2800 stay leap)
  always_comb begin
    century_skip = 1'b0;
    case (year_bin)
      12'd2100, 12'd2200, 12'd2300, 12'd2500,
      12'd2600, 12'd2700, 12'd2900, 12'd3000: century_skip = 1'b1;
      default: ;
    endcase
  end

  assign leap      = (year_bin[1:0] == 2'b00) && !century_skip;
  assign up_p      = up & ~up_q;
  assign down_p    = down & ~down_q;
  assign adj_day   = (select_item == SELECT_DAY);
  assign adj_month = (select_item == SELECT_MONTH);
  assign adj_mode  = adj_day | adj_month;
  assign count_ev  = en_1 & carry_in & ~adj_mode;
  // Simultaneous up and down rising edges cancel each other
  assign step_ev   = up_p ^ down_p;
  assign dim_cur   = days_in(month_q, leap);

  always_comb begin
    month_adj = month_q;
    if (up_p) begin
      month_adj = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
    end else begin
      month_adj = (month_q == 4'd1) ? 4'd12 : month_q - 4'd1;
    end
  end

  assign dim_new = days_in(month_adj, leap);

  always_comb begin
    day_d   = day_q;
    month_d = month_q;
    up_d    = up;
    down_d  = down;
    if (count_ev) begin
      if (day_q < dim_cur) begin
        day_d = day_q + 5'd1;
      end else begin
        day_d   = 5'd1;
        month_d = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
      end
    end else if (adj_day && step_ev) begin
      if (up_p) begin
        day_d = (day_q >= dim_cur) ? 5'd1 : day_q + 5'd1;
      end else begin
        day_d = (day_q == 5'd1) ? dim_cur : day_q - 5'd1;
      end
    end else if (adj_month && step_ev) begin
      month_d = month_adj;
      // Clamp against the new month on the same edge
      if (day_q > dim_new) begin
        day_d = dim_new;
      end
    end else if (day_q > dim_cur) begin
      // Idle clamp, e.g. Feb 29 after the year moves to a non-leap year
      day_d = dim_cur;
    end
  end

  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      day_q   <= 5'd1;
      month_q <= 4'd1;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      day_q   <= day_d;
      month_q <= month_d;
      up_q    <= up_d;
      down_q  <= down_d;
    end
  end

  assign day_bin   = day_q;
  assign month_bin = month_q;
  assign carry_out = count_ev & ~rst & (day_q == 5'd31) & (month_q == 4'd12);

endmodule
